// File: rtl/sparc_exu_div_pkg.sv
// sparc_exu_div_pkg: shared constants and FSM encoding for the EXU divide scheduler
package sparc_exu_div_pkg;
  localparam int NTHR_D = 4;
  localparam int RDW_D = 5;
  localparam int TIDW = 2;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    WB    = 2'd3
  } div_state_e;
endpackage

// File: rtl/sparc_exu_div_rrpick.sv
// sparc_exu_div_rrpick: four-way round-robin one-hot picker with registered last grant
module sparc_exu_div_rrpick
  import sparc_exu_div_pkg::*;
(
  input  logic              clk,
  input  logic              arst_l,
  input  logic [NTHR_D-1:0] cand,
  input  logic              adv,
  output logic [NTHR_D-1:0] gnt
);
  logic [NTHR_D-1:0] last;
  logic [TIDW-1:0] li, idx;
  logic found;
  always_comb begin
    li = '0;
    for (int i = 0; i < NTHR_D; i++) li = last[i] ? TIDW'(i) : li;
  end
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= NTHR_D; i++) begin
      idx = li + TIDW'(i);
      if (!found && cand[idx]) begin
        gnt[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge arst_l)
    if (!arst_l) last <= 4'b1000;
    else if (adv && |gnt) last <= gnt;
endmodule

// File: rtl/sparc_exu_div_sched.sv
// sparc_exu_div_sched: round-robin scheduler of four threads onto the shared EXU divider
module sparc_exu_div_sched
  import sparc_exu_div_pkg::*;
#(
  parameter int NTHR = NTHR_D,
  parameter int RDW  = RDW_D
) (
  input  logic            clk,
  input  logic            arst_l,
  input  logic [NTHR-1:0] req_vld,
  input  logic [RDW-1:0]  req_rd,
  input  logic [NTHR-1:0] kill_vec,
  output logic            div_start,
  output logic [1:0]      div_tid,
  output logic [RDW-1:0]  div_rd,
  input  logic            div_done,
  output logic            wb_vld,
  output logic [1:0]      wb_tid,
  output logic [RDW-1:0]  wb_rd,
  input  logic            wb_ack,
  output logic [NTHR-1:0] pend_vec,
  output logic            busy
);
  div_state_e state, state_nxt;
  logic [NTHR-1:0] pend, cand, gnt, cur_oh, pend_set, pend_clr;
  logic [RDW-1:0] rd_q [NTHR];
  logic [TIDW-1:0] cur_tid, gnt_tid;
  logic [RDW-1:0] cur_rd;
  logic squash, kill_cur, grant, op_end;

  assign kill_cur = kill_vec[cur_tid];
  assign cand = (state == IDLE) ? pend & ~kill_vec : '0;
  assign grant = |gnt;
  assign cur_oh = NTHR'(1) << cur_tid;
  assign op_end = (state == BUSY && div_done && (squash || kill_cur)) ||
                  (state == WB && (wb_ack || kill_cur));
  assign pend_set = req_vld & ~pend & ~kill_vec;
  assign pend_clr = (kill_vec & ~(busy ? cur_oh : '0)) | (op_end ? cur_oh : '0);

  sparc_exu_div_rrpick u_pick (
    .clk    (clk),
    .arst_l (arst_l),
    .cand   (cand),
    .adv    (grant),
    .gnt    (gnt)
  );

  always_comb begin
    gnt_tid = '0;
    for (int i = 0; i < NTHR; i++) gnt_tid = gnt[i] ? TIDW'(i) : gnt_tid;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant ? START : IDLE;
      START:   state_nxt = BUSY;
      BUSY:    state_nxt = !div_done ? BUSY : (squash || kill_cur) ? IDLE : WB;
      WB:      state_nxt = (wb_ack || kill_cur) ? IDLE : WB;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_l)
    if (!arst_l) begin
      state <= IDLE;
      cur_tid <= '0;
      cur_rd <= '0;
      squash <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant) begin
        cur_tid <= gnt_tid;
        cur_rd <= rd_q[gnt_tid];
        squash <= 1'b0;
      end else if ((state == START || state == BUSY) && kill_cur) begin
        squash <= 1'b1;
      end
    end

  always_ff @(posedge clk or negedge arst_l)
    if (!arst_l) begin
      pend <= '0;
      for (int t = 0; t < NTHR; t++) rd_q[t] <= '0;
    end else begin
      pend <= (pend | pend_set) & ~pend_clr;
      for (int t = 0; t < NTHR; t++) if (pend_set[t]) rd_q[t] <= req_rd;
    end

  assign busy = state != IDLE;
  assign div_start = state == START;
  assign div_tid = busy ? cur_tid : '0;
  assign div_rd = busy ? cur_rd : '0;
  assign wb_vld = state == WB;
  assign wb_tid = wb_vld ? cur_tid : '0;
  assign wb_rd = wb_vld ? cur_rd : '0;
  assign pend_vec = pend;

  a_req_onehot: assert property (@(posedge clk) disable iff (!arst_l) $onehot0(req_vld));
  a_req_dup:    assert property (@(posedge clk) disable iff (!arst_l) (req_vld & pend) == '0);
  a_done_busy:  assert property (@(posedge clk) disable iff (!arst_l) div_done |-> state == BUSY);
endmodule

// File: tb/tb_sparc_exu_div_sched.sv
// tb_sparc_exu_div_sched: directed table and sequence checks for the divide scheduler
module tb_sparc_exu_div_sched;
  logic clk = 1'b0, arst_l = 1'b1;
  logic [3:0] req_vld = '0, kill_vec = '0, pend_vec;
  logic [4:0] req_rd = '0, div_rd, wb_rd;
  logic div_done = 1'b0, wb_ack = 1'b0, div_start, wb_vld, busy;
  logic [1:0] div_tid, wb_tid;
  logic [20:0] obs;
  int pass = 0, total = 0;

  typedef struct {
    logic [3:0]  req;
    logic [4:0]  rd;
    logic        done;
    logic        ack;
    logic [20:0] exp;
  } vec_t;
  vec_t tbl [13];

  always #5 clk = ~clk;

  sparc_exu_div_sched dut (
    .clk       (clk),
    .arst_l    (arst_l),
    .req_vld   (req_vld),
    .req_rd    (req_rd),
    .kill_vec  (kill_vec),
    .div_start (div_start),
    .div_tid   (div_tid),
    .div_rd    (div_rd),
    .div_done  (div_done),
    .wb_vld    (wb_vld),
    .wb_tid    (wb_tid),
    .wb_rd     (wb_rd),
    .wb_ack    (wb_ack),
    .pend_vec  (pend_vec),
    .busy      (busy)
  );

  assign obs = {div_start, div_tid, div_rd, wb_vld, wb_tid, wb_rd, pend_vec, busy};

  function automatic logic [20:0] mk(input logic st, input logic [1:0] tid, input logic [4:0] rd,
                                     input logic wb, input logic [1:0] wt, input logic [4:0] wr,
                                     input logic [3:0] pd, input logic bz);
    return {st, tid, rd, wb, wt, wr, pd, bz};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [20:0] e);
    total++;
    if (obs === e) pass++;
    else $display("FAIL %s: got %h expected %h", n, obs, e);
  endtask

  task automatic chkv(input string n, input int got, input int want);
    total++;
    if (got == want) pass++;
    else $display("FAIL %s: got %0d expected %0d", n, got, want);
  endtask

  task automatic do_reset();
    arst_l = 1'b0;
    step();
    step();
    @(negedge clk);
    arst_l = 1'b1;
    step();
  endtask

  task automatic req(input int t, input logic [4:0] rd);
    req_vld = 4'(1 << t);
    req_rd = rd;
    step();
    req_vld = '0;
    req_rd = '0;
  endtask

  task automatic wait_start(input int t, input int rd);
    int n = 0;
    while (!div_start && n < 30) begin
      step();
      n++;
    end
    chkv($sformatf("start_tid_t%0d", t), div_start ? int'(div_tid) : -1, t);
    chkv($sformatf("start_rd_t%0d", t), int'(div_rd), rd);
  endtask

  task automatic finish_op(input int t, input int rd);
    step();
    step();
    div_done = 1'b1;
    step();
    div_done = 1'b0;
    chkv($sformatf("wb_t%0d", t), int'({wb_vld, wb_tid, wb_rd}), int'({1'b1, 2'(t), 5'(rd)}));
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    chkv($sformatf("idle_after_wb_t%0d", t), int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int starts;
    for (int i = 0; i < 13; i++)
      tbl[i] = '{4'b0, 5'd0, 1'b0, 1'b0, mk(1'b0, 2'd2, 5'd9, 1'b0, 2'd0, 5'd0, 4'b0100, 1'b1)};
    tbl[0] = '{4'b0100, 5'd9, 1'b0, 1'b0, 21'd0};
    tbl[1].exp = mk(1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 4'b0100, 1'b0);
    tbl[2].exp = mk(1'b1, 2'd2, 5'd9, 1'b0, 2'd0, 5'd0, 4'b0100, 1'b1);
    tbl[10].done = 1'b1;
    tbl[11].ack = 1'b1;
    tbl[11].exp = mk(1'b0, 2'd2, 5'd9, 1'b1, 2'd2, 5'd9, 4'b0100, 1'b1);
    tbl[12].exp = '0;
    #1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("single_c%0d", i), tbl[i].exp);
      req_vld = tbl[i].req;
      req_rd = tbl[i].rd;
      div_done = tbl[i].done;
      wb_ack = tbl[i].ack;
      step();
    end
    req_vld = '0;
    req_rd = '0;
    div_done = 1'b0;
    wb_ack = 1'b0;

    do_reset();
    req(0, 5'd1);
    req(3, 5'd13);
    wait_start(0, 1);
    req(2, 5'd12);
    req(1, 5'd11);
    finish_op(0, 1);
    wait_start(1, 11);
    finish_op(1, 11);
    wait_start(2, 12);
    req(1, 5'd21);
    finish_op(2, 12);
    wait_start(3, 13);
    finish_op(3, 13);
    wait_start(1, 21);
    finish_op(1, 21);
    chkv("fair_pend_empty", int'(pend_vec), 0);

    do_reset();
    req(0, 5'd3);
    req(1, 5'd4);
    wait_start(0, 3);
    chkv("kw_pend_both", int'(pend_vec), 3);
    kill_vec = 4'b0010;
    step();
    kill_vec = '0;
    chkv("kw_pend_clr", int'(pend_vec), 1);
    finish_op(0, 3);
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      starts += int'(div_start);
      step();
    end
    chkv("kw_no_start", starts, 0);
    chkv("kw_pend_empty", int'(pend_vec), 0);

    do_reset();
    req(0, 5'd7);
    wait_start(0, 7);
    step();
    kill_vec = 4'b0001;
    step();
    kill_vec = '0;
    chkv("kf_pend_held", int'(pend_vec), 1);
    div_done = 1'b1;
    step();
    div_done = 1'b0;
    chk("kf_dropped", '0);
    req(1, 5'd6);
    wait_start(1, 6);
    step();
    div_done = 1'b1;
    step();
    div_done = 1'b0;
    chkv("kwb_wb_vld", int'(wb_vld), 1);
    kill_vec = 4'b0010;
    step();
    kill_vec = '0;
    chk("kwb_dropped", '0);
    req(2, 5'd8);
    wait_start(2, 8);
    step();
    kill_vec = 4'b0100;
    div_done = 1'b1;
    step();
    kill_vec = '0;
    div_done = 1'b0;
    chk("kd_dropped", '0);

    do_reset();
    req(2, 5'd17);
    req(3, 5'd18);
    wait_start(2, 17);
    step();
    step();
    div_done = 1'b1;
    step();
    div_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wbstall_c%0d", i), mk(1'b0, 2'd2, 5'd17, 1'b1, 2'd2, 5'd17, 4'b1100, 1'b1));
      step();
    end
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    chk("wbstall_idle", mk(1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 4'b1000, 1'b0));
    wait_start(3, 18);
    finish_op(3, 18);

    req(1, 5'd5);
    wait_start(1, 5);
    step();
    #2;
    arst_l = 1'b0;
    #1;
    chk("arst_immediate", '0);
    div_done = 1'b1;
    step();
    div_done = 1'b0;
    @(negedge clk);
    arst_l = 1'b1;
    step();
    chk("arst_idle", '0);
    req(0, 5'd2);
    wait_start(0, 2);
    finish_op(0, 2);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
